// File: rtl/serial_parallel_deser_if.sv
// Bus bundle for serial_parallel_deser: the serial input side (bit valid,
// data bit, frame sync) and the parallel output side (held word, valid/ready
// handshake, bit count, sticky overrun with its clear).
interface serial_parallel_deser_if #(
  parameter int WIDTH = 8
);
  localparam int CW = $clog2(WIDTH);

  logic             enable_i;
  logic             sum_o_out_i;
  logic             start_i;
  logic             par_ready_i;
  logic             clr_overrun_i;
  logic [WIDTH-1:0] sum_o;
  logic             par_valid_o;
  logic [CW-1:0]    count_o;
  logic             overrun_o;

  // Producer/consumer side: drives the serial stream and the handshake ready.
  modport master (
    output enable_i,
    output sum_o_out_i,
    output start_i,
    output par_ready_i,
    output clr_overrun_i,
    input  sum_o,
    input  par_valid_o,
    input  count_o,
    input  overrun_o
  );

  // Deserializer side.
  modport slave (
    input  enable_i,
    input  sum_o_out_i,
    input  start_i,
    input  par_ready_i,
    input  clr_overrun_i,
    output sum_o,
    output par_valid_o,
    output count_o,
    output overrun_o
  );
endinterface

// File: rtl/serial_parallel_deser.sv
// Serial-to-parallel deserializer for the serial adder sum stream.
// Collects WIDTH enabled bits into a word (selectable bit order, frame-start
// resync), parks each completed word in a one-entry holding buffer drained by
// a valid/ready handshake, and flags words lost to backpressure on a sticky
// overrun flag. Every output comes straight from a flop.
module serial_parallel_deser #(
  parameter int WIDTH     = 8,
  parameter bit LSB_FIRST = 1'b1
) (
  input logic                    clk_i,
  input logic                    reset_n_i,  // active-high, asynchronous
  serial_parallel_deser_if.slave bus
);

  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } buf_state_t;

  // One-bit shift in the configured order; the newest bit ends up at the
  // opposite end from where the first bit of the word started.
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s,
                                                input logic             b);
    if (LSB_FIRST) begin
      return {b, s[WIDTH-1:1]};
    end else begin
      return {s[WIDTH-2:0], b};
    end
  endfunction

  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [WIDTH-1:0] hold_q;
  logic [WIDTH-1:0] shifted;
  logic             complete;
  logic             hold_load;
  logic             drop;
  logic             overrun_q;
  logic             overrun_d;
  buf_state_t       state_q;
  buf_state_t       state_d;

  assign shifted = shift_in(sreg_q, bus.sum_o_out_i);

  // A word completes only on a non-resync enabled bit that fills the last slot.
  assign complete = bus.enable_i && !bus.start_i && (cnt_q == CNT_LAST);

  // Shift register and bit counter next state; start_i restarts at bit 0.
  always_comb begin
    sreg_d = sreg_q;
    cnt_d  = cnt_q;
    if (bus.enable_i) begin
      sreg_d = shifted;
      if (bus.start_i) begin
        cnt_d = CW'(1);
      end else if (cnt_q == CNT_LAST) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Shift register and counter state.
  always_ff @(posedge clk_i or posedge reset_n_i) begin
    if (reset_n_i) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
    end
  end

  // Buffer FSM: decide next fill state, whether to load the holding register,
  // and whether a completed word has to be dropped.
  always_comb begin
    state_d   = state_q;
    hold_load = 1'b0;
    drop      = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (complete) begin
          state_d   = FULL;
          hold_load = 1'b1;
        end
      end
      FULL: begin
        if (complete) begin
          if (bus.par_ready_i) begin
            // Old word leaves on this edge while the new one takes its place.
            hold_load = 1'b1;
          end else begin
            drop = 1'b1;
          end
        end else if (bus.par_ready_i) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // A drop outranks a clear in the same cycle so no loss goes unreported.
  always_comb begin
    overrun_d = overrun_q;
    if (drop) begin
      overrun_d = 1'b1;
    end else if (bus.clr_overrun_i) begin
      overrun_d = 1'b0;
    end
  end

  // Buffer state, holding register and sticky overrun flag.
  always_ff @(posedge clk_i or posedge reset_n_i) begin
    if (reset_n_i) begin
      state_q   <= EMPTY;
      hold_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      overrun_q <= overrun_d;
      if (hold_load) begin
        hold_q <= shifted;
      end
    end
  end

  assign bus.sum_o       = hold_q;
  assign bus.par_valid_o = (state_q == FULL);
  assign bus.count_o     = cnt_q;
  assign bus.overrun_o   = overrun_q;

endmodule

// File: tb/tb_serial_parallel_deser.sv
// Bench for serial_parallel_deser: one LSB-first and one MSB-first instance
// fed the same serial stream. A bit-list reference model predicts every word;
// loaded words go into per-instance scoreboard queues that a negedge monitor
// drains on each handshake.
module tb_serial_parallel_deser;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  serial_parallel_deser_if #(.WIDTH(W)) bus0 ();
  serial_parallel_deser_if #(.WIDTH(W)) bus1 ();

  serial_parallel_deser #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
    .clk_i     (clk),
    .reset_n_i (rst),
    .bus       (bus0)
  );

  serial_parallel_deser #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
    .clk_i     (clk),
    .reset_n_i (rst),
    .bus       (bus1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit           m_bits[$];
  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];
  logic         m_full = 1'b0;
  logic         m_ovr  = 1'b0;
  logic [W-1:0] m_hold0 = '0;
  logic [W-1:0] m_hold1 = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] build(input bit lsb);
    logic [W-1:0] w;
    w = '0;
    for (int i = 0; i < W; i++) begin
      if (lsb) w[i] = m_bits[i];
      else     w[W-1-i] = m_bits[i];
    end
    return w;
  endfunction

  task automatic model_reset();
    m_bits.delete();
    q0.delete();
    q1.delete();
    m_full  = 1'b0;
    m_ovr   = 1'b0;
    m_hold0 = '0;
    m_hold1 = '0;
  endtask

  task automatic model_update(input logic en, input logic b, input logic st,
                              input logic rdy, input logic clr);
    logic         comp;
    logic         drop;
    logic [W-1:0] w0;
    logic [W-1:0] w1;
    comp = 1'b0;
    drop = 1'b0;
    w0   = '0;
    w1   = '0;
    if (en) begin
      if (st) m_bits.delete();
      m_bits.push_back(b);
      if (!st && m_bits.size() == W) begin
        w0   = build(1'b1);
        w1   = build(1'b0);
        comp = 1'b1;
        m_bits.delete();
      end
    end
    if (comp) begin
      if (!m_full || rdy) begin
        m_full  = 1'b1;
        m_hold0 = w0;
        m_hold1 = w1;
        q0.push_back(w0);
        q1.push_back(w1);
      end else begin
        drop = 1'b1;
      end
    end else if (m_full && rdy) begin
      m_full = 1'b0;
    end
    if (drop)     m_ovr = 1'b1;
    else if (clr) m_ovr = 1'b0;
  endtask

  task automatic check_state();
    chk("count_lsb",   32'(bus0.count_o),     32'(m_bits.size()));
    chk("count_msb",   32'(bus1.count_o),     32'(m_bits.size()));
    chk("valid_lsb",   32'(bus0.par_valid_o), 32'(m_full));
    chk("valid_msb",   32'(bus1.par_valid_o), 32'(m_full));
    chk("overrun_lsb", 32'(bus0.overrun_o),   32'(m_ovr));
    chk("overrun_msb", 32'(bus1.overrun_o),   32'(m_ovr));
    chk("hold_lsb",    32'(bus0.sum_o),       32'(m_hold0));
    chk("hold_msb",    32'(bus1.sum_o),       32'(m_hold1));
  endtask

  task automatic drive(input logic en, input logic b, input logic st,
                       input logic rdy, input logic clr);
    bus0.enable_i = en;  bus0.sum_o_out_i = b;  bus0.start_i = st;
    bus0.par_ready_i = rdy;  bus0.clr_overrun_i = clr;
    bus1.enable_i = en;  bus1.sum_o_out_i = b;  bus1.start_i = st;
    bus1.par_ready_i = rdy;  bus1.clr_overrun_i = clr;
  endtask

  // One clock: apply inputs, let the edge happen, advance model, compare.
  task automatic step(input logic en, input logic b, input logic st,
                      input logic rdy, input logic clr);
    drive(en, b, st, rdy, clr);
    @(posedge clk);
    model_update(en, b, st, rdy, clr);
    #1;
    check_state();
  endtask

  task automatic send_byte(input logic [W-1:0] v, input logic rdy_bits,
                           input logic rdy_last);
    for (int i = 0; i < W; i++)
      step(1'b1, v[i], i == 0, (i == W-1) ? rdy_last : rdy_bits, 1'b0);
  endtask

  task automatic drain();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_sum_lsb"},   32'(bus0.sum_o),       32'h0);
    chk({tag, "_sum_msb"},   32'(bus1.sum_o),       32'h0);
    chk({tag, "_valid"},     32'(bus0.par_valid_o), 32'h0);
    chk({tag, "_count"},     32'(bus0.count_o),     32'h0);
    chk({tag, "_overrun"},   32'(bus0.overrun_o),   32'h0);
    chk({tag, "_valid_msb"}, 32'(bus1.par_valid_o), 32'h0);
  endtask

  // Reset asserted between edges; outputs must clear before the next edge.
  task automatic reset_mid(input string tag);
    #1 rst = 1'b1;
    #1 check_zero(tag);
    model_reset();
    #1 rst = 1'b0;
  endtask

  // Monitor: a word is transferred on the coming edge when valid and ready.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus0.par_valid_o && bus0.par_ready_i) begin
        if (q0.size() == 0) chk("sb_lsb_underflow", 32'(q0.size()), 32'd1);
        else chk("sb_lsb_word", 32'(bus0.sum_o), 32'(q0.pop_front()));
      end
      if (bus1.par_valid_o && bus1.par_ready_i) begin
        if (q1.size() == 0) chk("sb_msb_underflow", 32'(q1.size()), 32'd1);
        else chk("sb_msb_word", 32'(bus1.sum_o), 32'(q1.pop_front()));
      end
    end
  end

  logic [7:0] pat;

  initial begin
    pat = 8'hA3;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    #3 check_zero("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Basic word, both bit orders from the same stream 1,1,0,0,0,1,0,1
    send_byte(8'hA3, 1'b0, 1'b0);
    chk("a3_lsb", 32'(bus0.sum_o), 32'hA3);
    chk("c5_msb", 32'(bus1.sum_o), 32'hC5);
    chk("a3_valid", 32'(bus0.par_valid_o), 32'h1);
    chk("a3_count", 32'(bus0.count_o), 32'h0);
    drain();

    // Same bits with enable low on alternate cycles
    for (int i = 0; i < W; i++) begin
      step(1'b1, pat[i], i == 0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    chk("alt_c5_msb", 32'(bus1.sum_o), 32'hC5);
    drain();

    // Backpressure: second word dropped, then cleared
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'h96, 1'b0, 1'b0);
    chk("bp_overrun", 32'(bus0.overrun_o), 32'h1);
    chk("bp_keep_first", 32'(bus0.sum_o), 32'h3C);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("bp_cleared", 32'(bus0.overrun_o), 32'h0);
    drain();

    // Ready on the completion cycle of the second word: replace, no overrun
    send_byte(8'h3C, 1'b0, 1'b0);
    send_byte(8'h96, 1'b0, 1'b1);
    chk("bp2_overrun", 32'(bus0.overrun_o), 32'h0);
    chk("bp2_second", 32'(bus0.sum_o), 32'h96);
    drain();

    // Resync after 5 bits
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("resync_count", 32'(bus0.count_o), 32'h1);
    for (int i = 0; i < 7; i++) step(1'b1, (i % 2) == 1, 1'b0, 1'b1, 1'b0);
    chk("resync_lsb", 32'(bus0.sum_o), 32'h55);
    chk("resync_msb", 32'(bus1.sum_o), 32'hAA);
    drain();

    // Reset mid-word, then a fresh word
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    reset_mid("rst_mid");
    send_byte(8'h5A, 1'b1, 1'b1);
    chk("after_rst_mid", 32'(bus0.sum_o), 32'h5A);
    drain();

    // Reset while FULL
    send_byte(8'hE7, 1'b0, 1'b0);
    reset_mid("rst_full");
    send_byte(8'h81, 1'b0, 1'b0);
    chk("after_rst_full", 32'(bus0.sum_o), 32'h81);
    drain();

    // Randomized stream
    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(3) != 0), $urandom_range(1) == 1,
           ($urandom_range(15) == 0), $urandom_range(1) == 1,
           ($urandom_range(7) == 0));
    end

    drain();
    drain();
    chk("end_q_lsb", 32'(q0.size()), 32'h0);
    chk("end_q_msb", 32'(q1.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
